// File: rtl/frontend_ocin_gen.sv
// -----------------------------------------------------------------------------
// frontend_ocin_gen
//
// Opto-coupler input / driven output frontend for one DIOB2 plugin slot group.
// Sits between the diob pin mapper and the blackbox internal_in/internal_out
// bus.
//
// Input path, per channel:
//   pin_in -> two sync flops -> debounce filter -> in_data
//   Changes of the debounced level are captured as rise/fall events into
//   sticky evt flags. Masked flags are ORed into a registered irq.
//
// Output path:
//   out_data -> registered pin_out, forced low while the plugin is disabled.
//   pin_dir is tied all-ones (every output and LED pin is driven).
//
// Status LEDs:
//   Each led_req pulse (re)loads a down-counter. The LED stays lit while the
//   counter is non-zero, so single-cycle bus events remain visible.
//
// Configuration check:
//   plugin_error flags blackbox enable bits that contradict the slot
//   direction: input slots with output_enable set without input_enable, and
//   output slots with input_enable set without output_enable.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   plugin_enable       plugin active; 0 forces pin_out low, blocks events
//   pin_in              raw asynchronous input pins          [N_IN]
//   in_data             debounced input levels               [N_IN]
//   out_data            output levels from internal_out      [N_OUT]
//   pin_out             registered output drive              [N_OUT]
//   pin_dir             constant all-ones direction          [N_OUT+N_LED]
//   rise_en, fall_en    per-channel edge capture enables     [N_IN]
//   evt                 sticky event flags                   [N_IN]
//   evt_clr             write-1-to-clear pulses for evt      [N_IN]
//   evt_mask            interrupt mask, 1 = enabled          [N_IN]
//   irq                 registered level interrupt
//   led_req             LED trigger pulses                   [N_LED]
//   led_out             stretched LED drive                  [N_LED]
//   input_enable        blackbox input-enable bits           [N_IN+N_OUT]
//   output_enable       blackbox output-enable bits          [N_IN+N_OUT]
//   plugin_error        registered configuration error
// -----------------------------------------------------------------------------
module frontend_ocin_gen #(
    parameter int N_IN        = 30,
    parameter int N_OUT       = 4,
    parameter int N_LED       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int LED_STRETCH = 2500000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   plugin_enable,
    input  logic [N_IN-1:0]        pin_in,
    output logic [N_IN-1:0]        in_data,
    input  logic [N_OUT-1:0]       out_data,
    output logic [N_OUT-1:0]       pin_out,
    output logic [N_OUT+N_LED-1:0] pin_dir,
    input  logic [N_IN-1:0]        rise_en,
    input  logic [N_IN-1:0]        fall_en,
    output logic [N_IN-1:0]        evt,
    input  logic [N_IN-1:0]        evt_clr,
    input  logic [N_IN-1:0]        evt_mask,
    output logic                   irq,
    input  logic [N_LED-1:0]       led_req,
    output logic [N_LED-1:0]       led_out,
    input  logic [N_IN+N_OUT-1:0]  input_enable,
    input  logic [N_IN+N_OUT-1:0]  output_enable,
    output logic                   plugin_error
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam int LW = (LED_STRETCH < 2) ? 1 : $clog2(LED_STRETCH + 1);
    localparam logic [LW-1:0] LED_LOAD = LW'(LED_STRETCH);

    logic [N_IN-1:0] sync1;
    logic [N_IN-1:0] sync2;
    logic [N_IN-1:0] stable;
    logic [N_IN-1:0] stable_d;
    logic [N_IN-1:0] evt_set;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin_in;
            sync2 <= sync1;
        end
    end

    // Debounce: the synchronised level must differ from the accepted level
    // for DEB_CYCLES consecutive samples before it is taken over. Any sample
    // that agrees again restarts the window.
    generate
        if (DEB_CYCLES == 0) begin : g_deb_bypass
            always_ff @(posedge clk) begin
                if (rst) begin
                    stable <= '0;
                end else begin
                    stable <= sync2;
                end
            end
        end else begin : g_deb
            localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
            for (genvar i = 0; i < N_IN; i++) begin : g_ch
                logic [DW-1:0] cnt;
                logic          level;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (sync2[i] == level) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        level <= sync2[i];
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end

                assign stable[i] = level;
            end
        end
    endgenerate

    assign in_data = stable;

    // Edges of the debounced level, compared against its previous value.
    assign evt_set = plugin_enable
                   ? ((stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en))
                   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d     <= '0;
            evt          <= '0;
            irq          <= 1'b0;
            pin_out      <= '0;
            plugin_error <= 1'b0;
        end else begin
            stable_d     <= stable;
            // A new event wins over a simultaneous clear.
            evt          <= (evt & ~evt_clr) | evt_set;
            irq          <= |(evt & evt_mask);
            pin_out      <= plugin_enable ? out_data : '0;
            plugin_error <= (|(output_enable[N_IN-1:0] & ~input_enable[N_IN-1:0])) |
                            (|(input_enable[N_IN+N_OUT-1:N_IN] &
                               ~output_enable[N_IN+N_OUT-1:N_IN]));
        end
    end

    assign pin_dir = '1;

    // LED stretchers: a request reloads the full on-time, so repeated
    // requests keep the LED lit until LED_STRETCH cycles after the last one.
    generate
        for (genvar j = 0; j < N_LED; j++) begin : g_led
            logic [LW-1:0] lcnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    lcnt <= '0;
                end else if (led_req[j]) begin
                    lcnt <= LED_LOAD;
                end else if (lcnt != '0) begin
                    lcnt <= lcnt - LW'(1);
                end
            end

            assign led_out[j] = (lcnt != '0);
        end
    endgenerate

endmodule

// File: tb/tb_frontend_ocin_gen.sv
// -----------------------------------------------------------------------------
// Testbench for frontend_ocin_gen. After every clock edge the reference model
// predicts the complete output state and pushes it into exp_q; the monitor
// compares the DUT against the head of the queue on the falling edge.
// -----------------------------------------------------------------------------
module tb_frontend_ocin_gen;

    localparam int NI  = 8;
    localparam int NO  = 4;
    localparam int NL  = 4;
    localparam int DEB = 4;
    localparam int LS  = 10;
    localparam int W   = NI + NO + NI + 1 + NL + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              plugin_enable;
    logic [NI-1:0]     pin_in;
    logic [NI-1:0]     in_data;
    logic [NO-1:0]     out_data;
    logic [NO-1:0]     pin_out;
    logic [NO+NL-1:0]  pin_dir;
    logic [NI-1:0]     rise_en, fall_en, evt, evt_clr, evt_mask;
    logic              irq;
    logic [NL-1:0]     led_req, led_out;
    logic [NI+NO-1:0]  input_enable, output_enable;
    logic              plugin_error;

    frontend_ocin_gen #(
        .N_IN(NI), .N_OUT(NO), .N_LED(NL), .DEB_CYCLES(DEB), .LED_STRETCH(LS)
    ) dut (
        .clk(clk), .rst(rst), .plugin_enable(plugin_enable),
        .pin_in(pin_in), .in_data(in_data),
        .out_data(out_data), .pin_out(pin_out), .pin_dir(pin_dir),
        .rise_en(rise_en), .fall_en(fall_en), .evt(evt), .evt_clr(evt_clr),
        .evt_mask(evt_mask), .irq(irq),
        .led_req(led_req), .led_out(led_out),
        .input_enable(input_enable), .output_enable(output_enable),
        .plugin_error(plugin_error)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Pin samples age through a two-deep history; a channel's accepted level
    // flips once the delayed pin has disagreed with it for DEB samples in a
    // row. LEDs are lit while fewer than LS edges have passed since the last
    // request.
    logic [NI-1:0] m_p1, m_s2, m_lvl, m_lvl_prev, m_evt, m_pout_dummy;
    logic [NO-1:0] m_pout;
    logic          m_irq, m_err;
    int            m_run[NI];
    int            m_age[NL];

    function automatic logic [NI-1:0] pending_set();
        if (!plugin_enable) return '0;
        return (m_lvl & ~m_lvl_prev & rise_en) | (~m_lvl & m_lvl_prev & fall_en);
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_evt = '0;
        m_pout = '0; m_irq = 1'b0; m_err = 1'b0;
        for (int i = 0; i < NI; i++) m_run[i] = 0;
        for (int j = 0; j < NL; j++) m_age[j] = LS;
    endtask

    task automatic model_step();
        logic [NI-1:0] nlvl;
        logic [NI-1:0] set;
        logic          e1, e2;
        if (rst) begin
            model_reset();
            return;
        end
        set  = pending_set();
        nlvl = m_lvl;
        for (int i = 0; i < NI; i++) begin
            if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] >= DEB) begin
                    nlvl[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end
        end
        m_irq = |(m_evt & evt_mask);
        m_evt = (m_evt & ~evt_clr) | set;
        m_lvl_prev = m_lvl;
        m_lvl  = nlvl;
        m_s2   = m_p1;
        m_p1   = pin_in;
        m_pout = plugin_enable ? out_data : '0;
        e1 = 1'b0; e2 = 1'b0;
        for (int i = 0; i < NI; i++)
            if (output_enable[i] && !input_enable[i]) e1 = 1'b1;
        for (int i = NI; i < NI + NO; i++)
            if (input_enable[i] && !output_enable[i]) e2 = 1'b1;
        m_err = e1 | e2;
        for (int j = 0; j < NL; j++) begin
            if (led_req[j]) m_age[j] = 0;
            else if (m_age[j] < LS) m_age[j]++;
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [NL-1:0] led;
        for (int j = 0; j < NL; j++) led[j] = (m_age[j] < LS);
        return {m_lvl, m_pout, m_evt, m_irq, led, m_err};
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        exp_q.push_back(model_out());
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial begin
        logic [W-1:0] e;
        logic [NO+NL-1:0] ones;
        ones = '1;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("in_data",      32'(in_data),      32'(e[W-1 -: NI]));
                chk("pin_out",      32'(pin_out),      32'(e[W-NI-1 -: NO]));
                chk("evt",          32'(evt),          32'(e[NL+1+NI -: NI]));
                chk("irq",          32'(irq),          32'(e[NL+1]));
                chk("led_out",      32'(led_out),      32'(e[NL -: NL]));
                chk("plugin_error", 32'(plugin_error), 32'(e[0]));
                chk("pin_dir",      32'(pin_dir),      32'(ones));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        rst = 1'b1; plugin_enable = 1'b1; pin_in = '0; out_data = '0;
        rise_en = '0; fall_en = '0; evt_clr = '0; evt_mask = '0; led_req = '0;
        input_enable = '0; output_enable = '0;
        model_reset();
        ticks(2);
        rst = 1'b0;
        input_enable  = {{NO{1'b0}}, {NI{1'b1}}};
        output_enable = {{NO{1'b1}}, {NI{1'b0}}};
        out_data = 4'b1010;
        ticks(2);

        // debounce: held level passes, short pulse is filtered
        rise_en = '1; fall_en = '1; evt_mask = '1;
        pin_in[3] = 1'b1;
        ticks(8);
        pin_in[5] = 1'b1; ticks(3); pin_in[5] = 1'b0;
        ticks(8);
        evt_clr = '1; tick(); evt_clr = '0; ticks(2);

        // rise-only channel 0 with interrupt, then clear
        rise_en = 8'h01; fall_en = '0; evt_mask = 8'h01;
        pin_in[0] = 1'b1; ticks(8);
        pin_in[0] = 1'b0; ticks(8);
        evt_clr[0] = 1'b1; tick(); evt_clr[0] = 1'b0; ticks(3);

        // event and clear in the same cycle on channel 2
        rise_en = 8'h04; evt_mask = 8'h04;
        pin_in[2] = 1'b1;
        guard = 0;
        while (pending_set() == '0 && guard < 20) begin tick(); guard++; end
        if (guard >= 20) begin
            errors++;
            $display("FAIL set_clr_align t=%0t actual=timeout required=edge", $time);
        end
        evt_clr[2] = 1'b1; tick(); evt_clr[2] = 1'b0; ticks(3);

        // disabled plugin: no events, pin_out low
        fall_en = 8'h08; rise_en = 8'h08; plugin_enable = 1'b0;
        pin_in[3] = 1'b0; ticks(10);
        plugin_enable = 1'b1; ticks(2);

        // LED stretch with retrigger
        led_req[1] = 1'b1; tick(); led_req[1] = 1'b0; ticks(5);
        led_req[1] = 1'b1; tick(); led_req[1] = 1'b0; ticks(12);

        // configuration error cases
        output_enable[0] = 1'b1; ticks(2); output_enable[0] = 1'b0; ticks(2);
        output_enable[NI] = 1'b0; input_enable[NI] = 1'b1; ticks(2);
        output_enable[NI] = 1'b1; input_enable[NI] = 1'b0; ticks(2);

        // reset in the middle of debounce and LED stretch
        pin_in[5] = 1'b1; led_req[2] = 1'b1; tick(); led_req[2] = 1'b0; ticks(3);
        rst = 1'b1; pin_in[5] = 1'b0; tick(); rst = 1'b0;
        ticks(10);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++)
                if ($urandom_range(15) == 0) pin_in[i] = ~pin_in[i];
            if (c % 100 == 0) begin
                rise_en  = NI'($urandom);
                fall_en  = NI'($urandom);
                evt_mask = NI'($urandom);
            end
            evt_clr = '0;
            for (int i = 0; i < NI; i++)
                if ($urandom_range(24) == 0) evt_clr[i] = 1'b1;
            led_req = '0;
            for (int j = 0; j < NL; j++)
                if ($urandom_range(19) == 0) led_req[j] = 1'b1;
            out_data = NO'($urandom);
            if ($urandom_range(49) == 0) plugin_enable = ~plugin_enable;
            if ($urandom_range(9) == 0) begin
                input_enable  = (NI+NO)'($urandom);
                output_enable = (NI+NO)'($urandom);
            end else if ($urandom_range(9) == 0) begin
                input_enable  = {{NO{1'b0}}, {NI{1'b1}}};
                output_enable = {{NO{1'b1}}, {NI{1'b0}}};
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(3);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain t=%0t actual=%0d required=0", $time, exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
